// File: rtl/interrupt_pkg.sv
// ---------------------------------------------------------------------------
// interrupt_pkg
// Shared types and constants for the interrupt tracker.
//   int_state_t        : per-source state, encoded as {running, pending}
//   SRC_NMI / SRC_IRQ  : default source indices (index 0 is highest priority)
//   DEFAULT_*          : default source count and edge/maskable configuration
// ---------------------------------------------------------------------------
package interrupt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PEND     = 2'b01,
        RUN      = 2'b10,
        RUN_PEND = 2'b11
    } int_state_t;

    localparam int SRC_NMI = 0;
    localparam int SRC_IRQ = 1;

    localparam int         DEFAULT_NUM_SRC   = 4;
    // NMI is the only edge-triggered source and the only non-maskable one.
    localparam logic [3:0] DEFAULT_EDGE_MASK = 4'b0001;
    localparam logic [3:0] DEFAULT_MASK_MASK = 4'b1110;

endpackage

// File: rtl/int_channel.sv
// ---------------------------------------------------------------------------
// int_channel
// One interrupt source: request capture (rising edge or level) and the
// IDLE / PEND / RUN / RUN_PEND state machine.
// Ports:
//   clk, nrst   : clock, asynchronous active-low reset
//   enableFfs   : core advance enable; freezes ack, done and level evaluation
//   srcReq      : synchronised request for this source
//   iFlag       : processor I flag (blocks the request if this source is maskable)
//   ack         : this source is being injected (already steered by the top)
//   done        : this source's handler retires (already steered by the top)
//   pending     : state bit 0
//   running     : state bit 1
// ---------------------------------------------------------------------------
module int_channel
    import interrupt_pkg::*;
#(
    parameter bit IS_EDGE     = 1'b0,
    parameter bit IS_MASKABLE = 1'b1
) (
    input  logic clk,
    input  logic nrst,
    input  logic enableFfs,
    input  logic srcReq,
    input  logic iFlag,
    input  logic ack,
    input  logic done,
    output logic pending,
    output logic running
);

    int_state_t state;
    int_state_t stateNext;
    logic       prevReq;
    logic       edgeSeen;
    logic       masked;
    logic       nextRun;
    logic       nextPend;

    // The history flop resets high so a request already asserted when reset
    // releases is not mistaken for a fresh rising edge.  It runs every cycle,
    // independent of enableFfs, so an edge during a stall is still seen.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prevReq <= 1'b1;
            state   <= IDLE;
        end else begin
            prevReq <= srcReq;
            state   <= stateNext;
        end
    end

    assign edgeSeen = srcReq & ~prevReq;
    assign masked   = IS_MASKABLE & iFlag;

    // Edge capture is applied last so it overrides an ack in the same cycle:
    // an acked source that sees a new edge ends in RUN_PEND.  Maskable edge
    // sources latch even while masked; the top decides eligibility.
    always_comb begin
        nextRun  = state[1];
        nextPend = state[0];
        if (enableFfs) begin
            if (ack) begin
                nextRun  = 1'b1;
                nextPend = 1'b0;
            end else if (done) begin
                nextRun  = 1'b0;
            end
            if (!IS_EDGE) begin
                nextPend = ack ? 1'b0 : (srcReq & ~masked);
            end
        end
        if (IS_EDGE && edgeSeen) begin
            nextPend = 1'b1;
        end
        stateNext = int_state_t'({nextRun, nextPend});
    end

    assign pending = state[0];
    assign running = state[1];

endmodule

// File: rtl/interrupt_tracker.sv
// ---------------------------------------------------------------------------
// interrupt_tracker
// Pending/running tracker for NUM_SRC fixed-priority, nestable interrupt
// sources.  Selects the vector to inject and steers ack/done to channels.
// Ports:
//   clk, nrst   : clock, asynchronous active-low reset
//   enable_ffs  : core advance enable; low stalls ack, done and level sampling
//   src_req     : synchronised active-high requests, bit 0 highest priority
//   i_flag      : processor I flag; 1 blocks maskable sources
//   int_ack     : core injects the vector for int_sel this cycle
//   int_done    : core retires a handler (RTI)
//   int_req     : some eligible source is pending
//   int_sel     : highest-priority eligible pending source, 0 when idle
//   pending     : per-source pending bits
//   running     : per-source running bits
//   any_running : OR of running
// ---------------------------------------------------------------------------
module interrupt_tracker
    import interrupt_pkg::*;
#(
    parameter int                 NUM_SRC   = DEFAULT_NUM_SRC,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = DEFAULT_EDGE_MASK,
    parameter logic [NUM_SRC-1:0] MASK_MASK = DEFAULT_MASK_MASK,
    parameter int                 IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               enable_ffs,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic               i_flag,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               int_req,
    output logic [IDX_W-1:0]   int_sel,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] running,
    output logic               any_running
);

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] innermost;
    logic [NUM_SRC-1:0] ackVec;
    logic [NUM_SRC-1:0] doneVec;
    logic               runAtOrAbove;
    logic               foundSel;
    logic               foundRun;

    for (genvar g = 0; g < NUM_SRC; g++) begin : genChannel
        int_channel #(
            .IS_EDGE     (EDGE_MASK[g]),
            .IS_MASKABLE (MASK_MASK[g])
        ) chan (
            .clk       (clk),
            .nrst      (nrst),
            .enableFfs (enable_ffs),
            .srcReq    (src_req[g]),
            .iFlag     (i_flag),
            .ack       (ackVec[g]),
            .done      (doneVec[g]),
            .pending   (pending[g]),
            .running   (running[g])
        );
    end

    // A source is eligible only if nothing at its own or a higher priority is
    // running.  Including its own running bit is what stops a handler from
    // re-entering itself.
    always_comb begin
        eligible     = '0;
        runAtOrAbove = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            runAtOrAbove = runAtOrAbove | running[i];
            eligible[i]  = pending[i] & ~(MASK_MASK[i] & i_flag) & ~runAtOrAbove;
        end
    end

    // Two lowest-index-first encoders: the vector to inject, and the
    // innermost (highest-priority) running handler that a done retires.
    always_comb begin
        int_sel   = '0;
        innermost = '0;
        foundSel  = 1'b0;
        foundRun  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && !foundSel) begin
                int_sel  = IDX_W'(i);
                foundSel = 1'b1;
            end
            if (running[i] && !foundRun) begin
                innermost[i] = 1'b1;
                foundRun     = 1'b1;
            end
        end
    end

    assign int_req     = |eligible;
    assign any_running = |running;

    // An ack with nothing eligible is dropped here; both steered strobes are
    // stall-gated so a frozen core cannot start or retire a handler.
    always_comb begin
        ackVec  = '0;
        doneVec = '0;
        if (enable_ffs && int_ack && int_req) begin
            ackVec[int_sel] = 1'b1;
        end
        if (enable_ffs && int_done) begin
            doneVec = innermost;
        end
    end

endmodule

// File: tb/tb_interrupt_tracker.sv
// ---------------------------------------------------------------------------
// tb_interrupt_tracker
// Directed self-checking bench for interrupt_tracker with default parameters.
// Expected output tuples are queued as each step is driven and popped when
// the outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_interrupt_tracker;
    import interrupt_pkg::*;

    typedef struct {
        string      tag;
        logic       req;
        logic [1:0] sel;
        logic [3:0] pend;
        logic [3:0] run;
    } exp_t;

    logic       clk;
    logic       nrst;
    logic       enableFfs;
    logic [3:0] srcReq;
    logic       iFlag;
    logic       intAck;
    logic       intDone;
    logic       intReq;
    logic [1:0] intSel;
    logic [3:0] pending;
    logic [3:0] running;
    logic       anyRunning;

    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    interrupt_tracker dut (
        .clk         (clk),
        .nrst        (nrst),
        .enable_ffs  (enableFfs),
        .src_req     (srcReq),
        .i_flag      (iFlag),
        .int_ack     (intAck),
        .int_done    (intDone),
        .int_req     (intReq),
        .int_sel     (intSel),
        .pending     (pending),
        .running     (running),
        .any_running (anyRunning)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: sequence did not complete, got running, required finish");
        $fatal(1, "[TB] timeout");
    end

    // Queue the outputs that must be visible after the next driven step.
    task automatic expectState(input string tag, input logic req, input logic [1:0] sel,
                               input logic [3:0] pend, input logic [3:0] run);
        exp_t e;
        e.tag  = tag;
        e.req  = req;
        e.sel  = sel;
        e.pend = pend;
        e.run  = run;
        scoreboard.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge, then advance to the next
    // falling edge so outputs are sampled away from the active edge.
    task automatic applyStimulus(input logic en, input logic [3:0] req, input logic flag,
                                 input logic ack, input logic done);
        enableFfs = en;
        srcReq    = req;
        iFlag     = flag;
        intAck    = ack;
        intDone   = done;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (scoreboard.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard: got empty queue, required an entry");
        end
        if (scoreboard.size() != 0) begin
            e = scoreboard.pop_front();
            checks++;
            assert (intReq === e.req) else begin
                errors++;
                $error("[TB] FAIL %s int_req: got %b required %b", e.tag, intReq, e.req);
            end
            checks++;
            assert (intSel === e.sel) else begin
                errors++;
                $error("[TB] FAIL %s int_sel: got %0d required %0d", e.tag, intSel, e.sel);
            end
            checks++;
            assert (pending === e.pend) else begin
                errors++;
                $error("[TB] FAIL %s pending: got %b required %b", e.tag, pending, e.pend);
            end
            checks++;
            assert (running === e.run) else begin
                errors++;
                $error("[TB] FAIL %s running: got %b required %b", e.tag, running, e.run);
            end
            checks++;
            assert (anyRunning === (|e.run)) else begin
                errors++;
                $error("[TB] FAIL %s any_running: got %b required %b", e.tag, anyRunning, |e.run);
            end
        end
    endtask

    initial begin
        nrst      = 1'b0;
        enableFfs = 1'b1;
        srcReq    = 4'b0000;
        iFlag     = 1'b0;
        intAck    = 1'b0;
        intDone   = 1'b0;
        $display("[TB] start");

        // Reset state
        repeat (2) @(negedge clk);
        expectState("reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
        checkOutput();
        nrst = 1'b1;
        expectState("idle", 1'b0, 2'd0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput();

        // 1. NMI edge captured during a 3-cycle stall; stalled ack is ignored
        expectState("stall1", 1'b1, 2'd0, 4'b0001, 4'b0000);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("stall2", 1'b1, 2'd0, 4'b0001, 4'b0000);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("stallAck", 1'b1, 2'd0, 4'b0001, 4'b0000);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0);
        checkOutput();
        expectState("enableBack", 1'b1, 2'd0, 4'b0001, 4'b0000);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("nmiAck", 1'b0, 2'd0, 4'b0000, 4'b0001);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 1'b0);
        checkOutput();
        expectState("nmiDone", 1'b0, 2'd0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput();

        // 2. IRQ level masked by i_flag, then unmasked, then dropped
        expectState("irqMasked", 1'b0, 2'd0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
        checkOutput();
        expectState("irqUnmasked", 1'b1, 2'd1, 4'b0010, 4'b0000);
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("irqDropped", 1'b0, 2'd0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput();

        // 3. Nesting: NMI preempts a running IRQ
        expectState("nestIrqPend", 1'b1, 2'd1, 4'b0010, 4'b0000);
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("nestIrqAck", 1'b0, 2'd0, 4'b0000, 4'b0010);
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0);
        checkOutput();
        expectState("nestIrqRun", 1'b0, 2'd0, 4'b0000, 4'b0010);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("nestNmiEdge", 1'b1, 2'd0, 4'b0001, 4'b0010);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("nestNmiAck", 1'b0, 2'd0, 4'b0000, 4'b0011);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 1'b0);
        checkOutput();
        expectState("nestDone1", 1'b0, 2'd0, 4'b0000, 4'b0010);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput();
        expectState("nestDone2", 1'b0, 2'd0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput();

        // 4. Lower-priority source waits while IRQ runs
        expectState("lowIrqPend", 1'b1, 2'd1, 4'b0010, 4'b0000);
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("lowIrqAck", 1'b0, 2'd0, 4'b0000, 4'b0010);
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0);
        checkOutput();
        expectState("lowSrc3Wait1", 1'b0, 2'd0, 4'b1000, 4'b0010);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("lowSrc3Wait2", 1'b0, 2'd0, 4'b1000, 4'b0010);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("lowIrqDone", 1'b1, 2'd3, 4'b1000, 4'b0000);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1'b1);
        checkOutput();
        expectState("lowSrc3Ack", 1'b0, 2'd0, 4'b0000, 4'b1000);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0);
        checkOutput();
        expectState("lowSrc3Done", 1'b0, 2'd0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput();

        // 5. Simultaneous ack (NMI), done (IRQ) and new NMI edge
        expectState("simIrqPend", 1'b1, 2'd1, 4'b0010, 4'b0000);
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("simIrqAck", 1'b0, 2'd0, 4'b0000, 4'b0010);
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0);
        checkOutput();
        expectState("simNmiEdge", 1'b1, 2'd0, 4'b0001, 4'b0010);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("simNmiLow", 1'b1, 2'd0, 4'b0001, 4'b0010);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("simAll", 1'b0, 2'd0, 4'b0001, 4'b0001);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 1'b1);
        checkOutput();
        expectState("simIdleAck", 1'b0, 2'd0, 4'b0001, 4'b0001);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 1'b0);
        checkOutput();
        expectState("simNmiDone", 1'b1, 2'd0, 4'b0001, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput();
        expectState("simNmiReAck", 1'b0, 2'd0, 4'b0000, 4'b0001);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput();
        expectState("simNmiReDone", 1'b0, 2'd0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput();

        // 6. Reset while running = 0011, NMI request held through release
        expectState("rstIrqPend", 1'b1, 2'd1, 4'b0010, 4'b0000);
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("rstIrqAck", 1'b0, 2'd0, 4'b0000, 4'b0010);
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0);
        checkOutput();
        expectState("rstNmiEdge", 1'b1, 2'd0, 4'b0001, 4'b0010);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("rstNmiAck", 1'b0, 2'd0, 4'b0000, 4'b0011);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 1'b0);
        checkOutput();

        intAck = 1'b0;
        nrst   = 1'b0;
        #1;
        expectState("rstAsync", 1'b0, 2'd0, 4'b0000, 4'b0000);
        checkOutput();
        @(negedge clk);
        nrst = 1'b1;
        expectState("rstRelease1", 1'b0, 2'd0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput();
        expectState("rstRelease2", 1'b0, 2'd0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
